// File: rtl/mem_access.sv
// mem_access: load/store unit between the execute stage and a valid/ready data bus.
// Define MEM_MISALIGN_TRAP_EN to turn misaligned accesses into exceptions instead of aligning them down.
module mem_access #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [1:0]              in_rw,
  input  logic [1:0]              in_size,
  input  logic                    in_unsigned,
  input  logic [ADDR_WIDTH-1:0]   in_addr,
  input  logic [DATA_WIDTH-1:0]   in_wdata,
  input  logic [DATA_WIDTH-1:0]   in_res,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    out_exc,
  input  logic                    flush,
  output logic                    dreq_valid,
  output logic [ADDR_WIDTH-1:0]   dreq_addr,
  output logic [1:0]              dreq_size,
  output logic [DATA_WIDTH/8-1:0] dreq_strobe,
  output logic [DATA_WIDTH-1:0]   dreq_data,
  input  logic                    dresp_addr_ok,
  input  logic                    dresp_data_ok,
  input  logic [DATA_WIDTH-1:0]   dresp_data
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(STRB_W);

  typedef enum logic [1:0] {IDLE, REQ, DATA, DONE} state_t;

  state_t                  r_state;
  logic                    r_outValid;
  logic                    r_outExc;
  logic [DATA_WIDTH-1:0]   r_outData;
  logic                    r_dreqValid;
  logic [ADDR_WIDTH-1:0]   r_dreqAddr;
  logic [STRB_W-1:0]       r_dreqStrobe;
  logic [DATA_WIDTH-1:0]   r_dreqData;
  logic [1:0]              r_size;
  logic [OFF_W-1:0]        r_off;
  logic                    r_isLoad;
  logic                    r_unsigned;
  logic                    r_flushed;

  logic                    w_isLoad;
  logic                    w_isStore;
  logic                    w_isMem;
  logic                    w_accept;
  logic                    w_trap;
  logic [1:0]              w_size;
  logic [3:0]              w_bytes;
  logic [ADDR_WIDTH-1:0]   w_lowMask;
  logic [ADDR_WIDTH-1:0]   w_alignedAddr;
  logic [OFF_W-1:0]        w_off;
  logic [STRB_W-1:0]       w_strobe;
  logic [DATA_WIDTH-1:0]   w_wdataShift;
  logic [DATA_WIDTH-1:0]   w_rdShift;
  logic [7:0]              w_dropBits;
  logic [DATA_WIDTH-1:0]   w_leftAligned;
  logic signed [DATA_WIDTH-1:0] w_signExt;
  logic [DATA_WIDTH-1:0]   w_loadData;
  logic [DATA_WIDTH-1:0]   w_result;

  assign in_ready    = (r_state == IDLE) || ((r_state == DONE) && out_ready);
  assign out_valid   = r_outValid;
  assign out_data    = r_outData;
  assign out_exc     = r_outExc;
  assign dreq_valid  = r_dreqValid;
  assign dreq_addr   = r_dreqAddr;
  assign dreq_size   = r_size;
  assign dreq_strobe = r_dreqStrobe;
  assign dreq_data   = r_dreqData;

  assign w_isLoad  = (in_rw == 2'b01);
  assign w_isStore = (in_rw == 2'b10);
  assign w_isMem   = w_isLoad || w_isStore;
  assign w_accept  = in_valid && in_ready && !flush;

  // A 32-bit bus cannot carry a doubleword, so size 3 collapses to a word.
  assign w_size        = ((DATA_WIDTH == 32) && (in_size == 2'd3)) ? 2'd2 : in_size;
  assign w_bytes       = 4'd1 << w_size;
  assign w_lowMask     = ADDR_WIDTH'(w_bytes - 4'd1);
  assign w_alignedAddr = in_addr & ~w_lowMask;
  assign w_off         = w_alignedAddr[OFF_W-1:0];
  assign w_strobe      = STRB_W'((1 << w_bytes) - 1) << w_off;
  assign w_wdataShift  = in_wdata << {w_off, 3'b000};

`ifdef MEM_MISALIGN_TRAP_EN
  assign w_trap = w_isMem && (|(in_addr & w_lowMask));
`else
  assign w_trap = 1'b0;
`endif

  // Left-justify the loaded field, then shift back down to zero- or sign-extend it.
  assign w_rdShift     = dresp_data >> {r_off, 3'b000};
  assign w_dropBits    = 8'(DATA_WIDTH) - (8'd8 << r_size);
  assign w_leftAligned = w_rdShift << w_dropBits;
  assign w_signExt     = $signed(w_leftAligned) >>> w_dropBits;
  assign w_loadData    = r_unsigned ? (w_leftAligned >> w_dropBits) : w_signExt;
  // Stores report zero as their result.
  assign w_result      = r_isLoad ? w_loadData : '0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= IDLE;
      r_outValid   <= 1'b0;
      r_outExc     <= 1'b0;
      r_outData    <= '0;
      r_dreqValid  <= 1'b0;
      r_dreqAddr   <= '0;
      r_dreqStrobe <= '0;
      r_dreqData   <= '0;
      r_size       <= '0;
      r_off        <= '0;
      r_isLoad     <= 1'b0;
      r_unsigned   <= 1'b0;
      r_flushed    <= 1'b0;
    end else begin
      case (r_state)
        REQ: begin
          if (flush) r_flushed <= 1'b1;
          if (dresp_addr_ok) begin
            r_dreqValid <= 1'b0;
            if (dresp_data_ok) begin
              if (r_flushed || flush) begin
                r_state <= IDLE;
              end else begin
                r_state    <= DONE;
                r_outValid <= 1'b1;
                r_outData  <= w_result;
              end
            end else begin
              r_state <= DATA;
            end
          end
        end
        DATA: begin
          if (flush) r_flushed <= 1'b1;
          if (dresp_data_ok) begin
            if (r_flushed || flush) begin
              r_state <= IDLE;
            end else begin
              r_state    <= DONE;
              r_outValid <= 1'b1;
              r_outData  <= w_result;
            end
          end
        end
        DONE: begin
          if (flush || out_ready) begin
            r_state    <= IDLE;
            r_outValid <= 1'b0;
            r_outExc   <= 1'b0;
          end
        end
        default: ;
      endcase

      // Acceptance can only happen in IDLE or a draining DONE, so it overrides the case above.
      if (w_accept) begin
        r_outExc <= 1'b0;
        if (!w_isMem) begin
          r_state    <= DONE;
          r_outValid <= 1'b1;
          r_outData  <= in_res;
        end else if (w_trap) begin
          r_state    <= DONE;
          r_outValid <= 1'b1;
          r_outExc   <= 1'b1;
          r_outData  <= DATA_WIDTH'(in_addr);
        end else begin
          r_state      <= REQ;
          r_outValid   <= 1'b0;
          r_dreqValid  <= 1'b1;
          r_dreqAddr   <= w_alignedAddr;
          r_dreqStrobe <= w_isStore ? w_strobe : '0;
          r_dreqData   <= w_isStore ? w_wdataShift : '0;
          r_size       <= w_size;
          r_off        <= w_off;
          r_isLoad     <= w_isLoad;
          r_unsigned   <= in_unsigned;
          r_flushed    <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Testbench for mem_access: directed scenarios plus randomized ops against a byte-level model.
// Expects the default build unless MEM_MISALIGN_TRAP_EN is defined for both bench and design.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_rw;
  logic [1:0]  in_size;
  logic        in_unsigned;
  logic [63:0] in_addr;
  logic [63:0] in_wdata;
  logic [63:0] in_res;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        out_exc;
  logic        flush;
  logic        dreq_valid;
  logic [63:0] dreq_addr;
  logic [1:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_data;
  logic        dresp_addr_ok;
  logic        dresp_data_ok;
  logic [63:0] dresp_data;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  always #5 clk = ~clk;

  mem_access #(.DATA_WIDTH(64), .ADDR_WIDTH(64)) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready), .in_rw(in_rw), .in_size(in_size),
    .in_unsigned(in_unsigned), .in_addr(in_addr), .in_wdata(in_wdata), .in_res(in_res),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_exc(out_exc),
    .flush(flush),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data)
  );

  // Reference model: pick the addressed bytes out of the bus word and extend them.
  function automatic logic [63:0] modelLoad(input logic [63:0] rdata, input int off,
                                            input int bytes, input logic uns);
    logic [63:0] v = '0;
    for (int b = 0; b < bytes; b++) v[8*b +: 8] = rdata[8*(off+b) +: 8];
    if (!uns && v[8*bytes-1])
      for (int b = bytes; b < 8; b++) v[8*b +: 8] = 8'hFF;
    return v;
  endfunction

  function automatic logic [7:0] modelStrobe(input int off, input int bytes);
    logic [7:0] s = '0;
    for (int b = 0; b < 8; b++) s[b] = (b >= off) && (b < off + bytes);
    return s;
  endfunction

  function automatic logic [63:0] modelStoreData(input logic [63:0] wdata, input int off);
    logic [63:0] d = '0;
    for (int b = 0; b < 8; b++) if (b >= off) d[8*b +: 8] = wdata[8*(b-off) +: 8];
    return d;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Present one op from IDLE and let it be accepted on the next edge.
  task automatic applyStimulus(input logic [1:0] rw, input logic [1:0] size, input logic uns,
                               input logic [63:0] addr, input logic [63:0] wdata,
                               input logic [63:0] res);
    in_valid = 1'b1; in_rw = rw; in_size = size; in_unsigned = uns;
    in_addr = addr; in_wdata = wdata; in_res = res;
    checkOutput("in_ready_idle", in_ready, 1);
    tick();
    in_valid = 1'b0;
    in_wdata = {$urandom, $urandom};
    in_res   = {$urandom, $urandom};
  endtask

  // Bus slave: addr_ok after addrDelay cycles, data_ok dataDelay cycles later; optional flush pulse.
  task automatic runBus(input int addrDelay, input int dataDelay, input logic [63:0] rdata,
                        input logic [63:0] expAddr, input logic [1:0] expSize,
                        input logic [7:0] expStrobe, input logic [63:0] expData,
                        input bit checkData, input int flushAt);
    int cyc = 0;
    for (int i = 0; i <= addrDelay; i++) begin
      checkOutput("dreq_valid", dreq_valid, 1);
      checkOutput("dreq_addr", dreq_addr, expAddr);
      checkOutput("dreq_size", dreq_size, expSize);
      checkOutput("dreq_strobe", dreq_strobe, expStrobe);
      if (checkData) checkOutput("dreq_data", dreq_data, expData);
      checkOutput("in_ready_busy", in_ready, 0);
      flush = (cyc == flushAt);
      if (i == addrDelay) begin
        dresp_addr_ok = 1'b1;
        if (dataDelay == 0) begin dresp_data_ok = 1'b1; dresp_data = rdata; end
      end
      tick(); cyc++;
      dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; flush = 1'b0;
      dresp_data = {$urandom, $urandom};
    end
    for (int j = 1; j <= dataDelay; j++) begin
      checkOutput("dreq_dropped", dreq_valid, 0);
      checkOutput("out_valid_busy", out_valid, 0);
      flush = (cyc == flushAt);
      if (j == dataDelay) begin dresp_data_ok = 1'b1; dresp_data = rdata; end
      tick(); cyc++;
      dresp_data_ok = 1'b0; flush = 1'b0;
      dresp_data = {$urandom, $urandom};
    end
  endtask

  // Check the DONE result, hold it for 'stall' cycles, then drain to IDLE.
  task automatic checkResult(input logic [63:0] expData, input bit checkData,
                             input logic expExc, input int stall);
    checkOutput("out_valid", out_valid, 1);
    checkOutput("out_exc", out_exc, expExc);
    if (checkData) checkOutput("out_data", out_data, expData);
    for (int k = 0; k < stall; k++) begin
      checkOutput("in_ready_stall", in_ready, 0);
      tick();
      checkOutput("out_valid_hold", out_valid, 1);
      if (checkData) checkOutput("out_data_hold", out_data, expData);
    end
    out_ready = 1'b1;
    #1;
    checkOutput("in_ready_drain", in_ready, 1);
    tick();
    out_ready = 1'b0;
    checkOutput("out_valid_clear", out_valid, 0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [1:0]  rw, size;
    logic        uns, isMem, expTrap;
    logic [63:0] addr, wdata, res, rdata, aligned;
    int          bytes, off, ad, dd, stall;

    resetn = 1'b0; in_valid = 1'b0; in_rw = 2'b00; in_size = 2'd0; in_unsigned = 1'b0;
    in_addr = '0; in_wdata = '0; in_res = '0; out_ready = 1'b0; flush = 1'b0;
    dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = '0;
    @(negedge clk);
    tick();
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_dreq_valid", dreq_valid, 0);
    checkOutput("rst_out_exc", out_exc, 0);
    checkOutput("rst_out_data", out_data, 0);
    checkOutput("rst_dreq_strobe", dreq_strobe, 0);
    checkOutput("rst_dreq_addr", dreq_addr, 0);
    checkOutput("rst_in_ready", in_ready, 1);
    resetn = 1'b1;
    tick();

    $display("[TB] signed byte load, addr_ok and data_ok together");
    applyStimulus(2'b01, 2'd0, 1'b0, 64'h1003, '0, '0);
    runBus(0, 0, 64'h0000_0000_8000_0000, 64'h1003, 2'd0, 8'h00, '0, 0, -1);
    checkResult(64'hFFFF_FFFF_FFFF_FF80, 1, 1'b0, 0);

    $display("[TB] half store with delayed addr_ok");
    applyStimulus(2'b10, 2'd1, 1'b0, 64'h2006, 64'hBEEF, '0);
    runBus(3, 0, '0, 64'h2006, 2'd1, 8'hC0, 64'hBEEF_0000_0000_0000, 1, -1);
    checkResult('0, 0, 1'b0, 0);

    $display("[TB] unsigned word load, slow data, downstream stall");
    applyStimulus(2'b01, 2'd2, 1'b1, 64'h3004, '0, '0);
    runBus(0, 5, 64'hDEAD_BEEF_1234_5678, 64'h3004, 2'd2, 8'h00, '0, 0, -1);
    checkResult(64'h0000_0000_DEAD_BEEF, 1, 1'b0, 2);

    $display("[TB] flush during DATA");
    applyStimulus(2'b01, 2'd3, 1'b0, 64'h5000, '0, '0);
    runBus(0, 3, 64'h1234_5678_9ABC_DEF0, 64'h5000, 2'd3, 8'h00, '0, 0, 2);
    checkOutput("flush_data_no_valid", out_valid, 0);
    checkOutput("flush_data_idle", in_ready, 1);
    tick();
    checkOutput("flush_data_no_valid_later", out_valid, 0);

    $display("[TB] flush during REQ");
    applyStimulus(2'b10, 2'd2, 1'b0, 64'h6008, 64'h0102_0304, '0);
    runBus(2, 1, '0, 64'h6008, 2'd2, 8'h0F, 64'h0102_0304, 1, 0);
    checkOutput("flush_req_no_valid", out_valid, 0);
    checkOutput("flush_req_idle", in_ready, 1);

    $display("[TB] flush in DONE and flush against acceptance");
    applyStimulus(2'b00, 2'd0, 1'b0, '0, '0, 64'hCAFE);
    checkOutput("done_valid", out_valid, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checkOutput("flush_done_clear", out_valid, 0);
    in_valid = 1'b1; in_rw = 2'b11; in_res = 64'h77; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    checkOutput("flush_accept_no_valid", out_valid, 0);
    checkOutput("flush_accept_no_req", dreq_valid, 0);
    checkOutput("flush_accept_idle", in_ready, 1);

    $display("[TB] misaligned word load");
    applyStimulus(2'b01, 2'd2, 1'b0, 64'h1002, '0, '0);
`ifdef MEM_MISALIGN_TRAP_EN
    checkOutput("trap_no_req", dreq_valid, 0);
    checkResult(64'h1002, 1, 1'b1, 0);
`else
    runBus(0, 0, 64'h1111_2222_3333_4444, 64'h1000, 2'd2, 8'h00, '0, 0, -1);
    checkResult(64'h3333_4444, 1, 1'b0, 0);
`endif

    $display("[TB] back-to-back non-memory ops");
    out_ready = 1'b1;
    in_valid  = 1'b1; in_rw = 2'b00;
    for (int n = 0; n < 4; n++) begin
      res = {$urandom, $urandom};
      in_res = res;
      tick();
      checkOutput("b2b_valid", out_valid, 1);
      checkOutput("b2b_data", out_data, res);
      checkOutput("b2b_in_ready", in_ready, 1);
    end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    checkOutput("b2b_drain", out_valid, 0);

    $display("[TB] new load accepted while draining DONE");
    applyStimulus(2'b11, 2'd0, 1'b0, '0, '0, 64'h55);
    out_ready = 1'b1; in_valid = 1'b1; in_rw = 2'b01; in_size = 2'd3; in_unsigned = 1'b0;
    in_addr = 64'h4000;
    #1;
    checkOutput("chain_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    checkOutput("chain_no_valid", out_valid, 0);
    runBus(0, 1, 64'h8765_4321_0FED_CBA9, 64'h4000, 2'd3, 8'h00, '0, 0, -1);
    checkResult(64'h8765_4321_0FED_CBA9, 1, 1'b0, 0);

    $display("[TB] reset mid-transaction");
    applyStimulus(2'b01, 2'd1, 1'b0, 64'h7002, '0, '0);
    resetn = 1'b0;
    #1;
    checkOutput("rst_mid_dreq", dreq_valid, 0);
    checkOutput("rst_mid_addr", dreq_addr, 0);
    checkOutput("rst_mid_valid", out_valid, 0);
    @(negedge clk);
    resetn = 1'b1;
    dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1; dresp_data = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0;
    checkOutput("late_resp_no_valid", out_valid, 0);
    checkOutput("late_resp_no_req", dreq_valid, 0);
    checkOutput("late_resp_idle", in_ready, 1);

    $display("[TB] randomized ops");
    for (int n = 0; n < 40; n++) begin
      rw = 2'($urandom_range(0, 3)); size = 2'($urandom_range(0, 3));
      uns = 1'($urandom_range(0, 1));
      addr = {$urandom, $urandom}; wdata = {$urandom, $urandom};
      res = {$urandom, $urandom}; rdata = {$urandom, $urandom};
      ad = $urandom_range(0, 3); dd = $urandom_range(0, 3); stall = $urandom_range(0, 2);
      bytes   = 1 << size;
      aligned = addr - (addr % bytes);
      off     = int'(aligned % 8);
      isMem   = (rw == 2'b01) || (rw == 2'b10);
`ifdef MEM_MISALIGN_TRAP_EN
      expTrap = isMem && ((addr % bytes) != 0);
`else
      expTrap = 1'b0;
`endif
      applyStimulus(rw, size, uns, addr, wdata, res);
      if (!isMem) begin
        checkResult(res, 1, 1'b0, stall);
      end else if (expTrap) begin
        checkOutput("rnd_trap_no_req", dreq_valid, 0);
        checkResult(addr, 1, 1'b1, stall);
      end else begin
        runBus(ad, dd, rdata, aligned, size,
               (rw == 2'b10) ? modelStrobe(off, bytes) : 8'h00,
               modelStoreData(wdata, off), rw == 2'b10, -1);
        checkResult((rw == 2'b01) ? modelLoad(rdata, off, bytes, uns) : 64'h0,
                    rw == 2'b01, 1'b0, stall);
      end
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
